concat_byte_serializer: RTL and testbench
=========================================

// Module: concat_byte_serializer
// PURPOSE
//  Downstream stage of the 4x18-bit -> 9-byte sample concatenator.
//  - Accepts one 9-byte word per valid/ready handshake.
//  - Emits the word as an AXI-Stream-style byte stream toward the UDP packetizer.
//  - Asserts tlast on the final byte of every WORDS_PER_PKT-word packet.
//  - Sustains 1 byte/clk with back-to-back words.
// PARAMETERS
//  BYTES_PER_WORD  9   bytes per input word (fixed by concatenator: 4x18b = 72b)
//  WORDS_PER_PKT   16  input words per output packet (>=1); packet = 144 bytes default
//  PKT_CNT_W       16  width of packet sequence counter
// PORTS
//  clk         in   1    system clock
//  arst        in   1    asynchronous reset, active-high
//  in_data     in   8 x BYTES_PER_WORD  unpacked byte array; in_data[0] sent first
//  in_valid    in   1    in_data valid
//  in_ready    out  1    block can accept a word this cycle
//  m_tdata     out  8    output byte
//  m_tvalid    out  1    m_tdata valid
//  m_tready    in   1    downstream accepts byte
//  m_tlast     out  1    last byte of packet
//  pkt_count   out  PKT_CNT_W  number of packets completed (wraps)
// BEHAVIOUR
//  Reset (async assert, sync release): m_tvalid=0, m_tlast=0, m_tdata=0, in_ready=0
//   while arst high, in_ready=1 first clk after release, byte_idx=0, word_idx=0,
//   pkt_count=0, holding register cleared.
//  States:
//   - EMPTY: holding reg invalid, in_ready=1.
//   - SEND: holding reg valid, m_tvalid=1.
//  Input accept = in_valid && in_ready; word latched into holding reg at that clk edge.
//  Latency: word accepted on edge N -> byte 0 on m_tdata with m_tvalid=1 after edge N.
//  Byte transfer = m_tvalid && m_tready; byte_idx advances 0..BYTES_PER_WORD-1.
//  m_tdata = hold[byte_idx] (mux of registered state, no combinational path from in_data).
//  in_ready = EMPTY || (m_tvalid && m_tready && byte_idx==BYTES_PER_WORD-1).
//  No in_ready path from in_valid.
//  Last-byte transfer:
//   - with new accept same cycle: reload hold, byte_idx=0, stay SEND (no bubble);
//   - without: -> EMPTY, m_tvalid=0 next cycle.
//  word_idx increments on each last-byte transfer; wraps to 0 after WORDS_PER_PKT-1.
//  m_tlast = m_tvalid && byte_idx==BYTES_PER_WORD-1 && word_idx==WORDS_PER_PKT-1.
//  pkt_count increments on the transfer carrying tlast; wraps 2^PKT_CNT_W-1 -> 0.
//  Backpressure (m_tready=0):
//   - m_tdata/m_tvalid/m_tlast held stable; no index advances;
//   - in_ready=0 while in SEND.
//  Stalled byte is never dropped or duplicated; m_tvalid never deasserts without a transfer.
//  in_valid while in_ready=0: ignored; upstream must hold data (AXI rule).
//  Reset mid-packet: partial word and packet discarded, no tlast emitted, counters to 0.
//  Next word after reset starts a new packet at word_idx=0.
//  WORDS_PER_PKT=1: tlast on byte 8 of every word.
// TESTING
//  1. Single word 01..09, m_tready=1 -> bytes 01,02..09 on 9 consecutive clks starting
//     1 clk after accept, tlast=0, then m_tvalid=0.
//  2. WORDS_PER_PKT=2, in_valid held high, m_tready=1 -> 18 contiguous bytes, no bubble.
//     tlast only on byte 18; pkt_count 0->1.
//  3. Word 01..09, m_tready low for 5 clks at byte 04 -> 04 held stable 5 clks.
//     in_ready=0 throughout; stream resumes 05..09 intact.
//  4. Random m_tready (50%) and in_valid, 1000 words, WORDS_PER_PKT=16
//     -> scoreboard byte order exact; tlast every 144 bytes; pkt_count=62.
//  5. arst pulse after byte 3 of word 5 -> m_tvalid=0 immediately; pkt_count=0.
//     Next packet of 16 words emits tlast on its 144th byte.
//  6. PKT_CNT_W=4, 17 packets -> pkt_count wraps 15->0->1.

Source files
------------

// File: rtl/concat_byte_serializer.sv
// Byte serializer: one BYTES_PER_WORD word per handshake out as an AXI-S byte stream, tlast every WORDS_PER_PKT words.
// Byte 0 appears 1 clk after accept; m_tready low freezes the stream and holds in_ready low while a word is in flight.
module concat_byte_serializer #(
    parameter int BYTES_PER_WORD = 9,
    parameter int WORDS_PER_PKT  = 16,
    parameter int PKT_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [7:0]           in_data [BYTES_PER_WORD],
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WIDX_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_PKT - 1);

    typedef enum logic {
        S_EMPTY,
        S_SEND
    } state_t;

    state_t                r_state;
    logic [7:0]            r_hold [BYTES_PER_WORD];
    logic [IDX_W-1:0]      r_byte_idx;
    logic [WIDX_W-1:0]     r_word_idx;
    logic [PKT_CNT_W-1:0]  r_pkt_count;
    logic                  r_rst_done;

    logic w_last_byte;
    logic w_xfer;
    logic w_last_xfer;
    logic w_accept;

    assign m_tvalid    = (r_state == S_SEND);
    assign m_tdata     = r_hold[r_byte_idx];
    assign w_last_byte = (r_byte_idx == LAST_BYTE);
    assign m_tlast     = m_tvalid && w_last_byte && (r_word_idx == LAST_WORD);
    assign w_xfer      = m_tvalid && m_tready;
    assign w_last_xfer = w_xfer && w_last_byte;
    // r_rst_done keeps in_ready low for the first clock after reset release.
    assign in_ready    = r_rst_done && ((r_state == S_EMPTY) || w_last_xfer);
    assign w_accept    = in_valid && in_ready;
    assign pkt_count   = r_pkt_count;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= S_EMPTY;
            r_hold      <= '{default: 8'h00};
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
            r_pkt_count <= '0;
            r_rst_done  <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_accept) begin
                r_hold     <= in_data;
                r_byte_idx <= '0;
                r_state    <= S_SEND;
            end else if (w_last_xfer) begin
                r_byte_idx <= '0;
                r_state    <= S_EMPTY;
            end else if (w_xfer) begin
                r_byte_idx <= r_byte_idx + IDX_W'(1);
            end

            if (w_last_xfer) begin
                r_word_idx <= (r_word_idx == LAST_WORD) ? '0 : r_word_idx + WIDX_W'(1);
                if (m_tlast) begin
                    r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_concat_byte_serializer.sv
// Three serializers (16, 2 and 1 words/packet) share one stimulus; a byte-queue model predicts every output each cycle.
module tb_concat_byte_serializer;
    localparam int P_A = 9 * 16;
    localparam int P_B = 9 * 2;
    localparam int P_C = 9 * 1;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] in_data [9];
    logic       in_valid;
    logic       m_tready;

    logic        rdy_a, vld_a, lst_a;
    logic        rdy_b, vld_b, lst_b;
    logic        rdy_c, vld_c, lst_c;
    logic [7:0]  dat_a, dat_b, dat_c;
    logic [15:0] pc_a;
    logic [3:0]  pc_b;
    logic [7:0]  pc_c;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;

    byte unsigned exp_q[$];
    int unsigned  bytes_sent = 0;
    bit           rdy_en = 0;

    always #5 clk = ~clk;

    concat_byte_serializer #(.BYTES_PER_WORD(9), .WORDS_PER_PKT(16), .PKT_CNT_W(16)) dut_a (
        .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
        .m_tdata(dat_a), .m_tvalid(vld_a), .m_tready(m_tready), .m_tlast(lst_a), .pkt_count(pc_a));
    concat_byte_serializer #(.BYTES_PER_WORD(9), .WORDS_PER_PKT(2), .PKT_CNT_W(4)) dut_b (
        .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
        .m_tdata(dat_b), .m_tvalid(vld_b), .m_tready(m_tready), .m_tlast(lst_b), .pkt_count(pc_b));
    concat_byte_serializer #(.BYTES_PER_WORD(9), .WORDS_PER_PKT(1), .PKT_CNT_W(8)) dut_c (
        .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_c),
        .m_tdata(dat_c), .m_tvalid(vld_c), .m_tready(m_tready), .m_tlast(lst_c), .pkt_count(pc_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet of P bytes: tlast on the byte whose stream offset is P-1 mod P; counter = full packets mod 2^W.
    task automatic chk_dut(input string nm, input int P, input int W, input logic [7:0] d,
                           input logic v, input logic l, input logic r, input logic [15:0] pc,
                           input bit ev, input bit er, input logic [7:0] ed);
        logic [31:0] epc;
        epc = (bytes_sent / P) % (1 << W);
        chk({nm, "_tvalid"}, v, ev);
        chk({nm, "_in_ready"}, r, er);
        chk({nm, "_tlast"}, l, ev && ((bytes_sent % P) == P - 1));
        chk({nm, "_pkt_count"}, pc, epc);
        if (ev) chk({nm, "_tdata"}, d, ed);
    endtask

    always @(negedge clk) begin
        bit         ev, er, xf;
        logic [7:0] ed;
        if (arst) begin
            exp_q.delete();
            bytes_sent = 0;
            rdy_en = 0;
        end
        ev = (exp_q.size() != 0);
        xf = ev && m_tready;
        er = rdy_en && (!ev || (exp_q.size() == 1 && xf));
        ed = ev ? exp_q[0] : 8'h00;
        chk_dut("a", P_A, 16, dat_a, vld_a, lst_a, rdy_a, pc_a, ev, er, ed);
        chk_dut("b", P_B, 4, dat_b, vld_b, lst_b, rdy_b, {12'h0, pc_b}, ev, er, ed);
        chk_dut("c", P_C, 8, dat_c, vld_c, lst_c, rdy_c, {8'h0, pc_c}, ev, er, ed);
        if (xf) begin
            void'(exp_q.pop_front());
            bytes_sent++;
        end
        if (in_valid && er) begin
            for (int i = 0; i < 9; i++) exp_q.push_back(in_data[i]);
        end
        if (!arst) rdy_en = 1;
    end

    always @(posedge clk) begin
        #1;
        m_tready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 9; i++) in_data[i] = base + 8'(i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 9; i++) in_data[i] = 8'($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_word();
        logic got;
        in_valid = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            got = rdy_a;
            @(posedge clk);
            #1;
            if (got) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL send_word: in_ready never seen within 500 clks at %0t", $time);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        arst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    task automatic drain();
        mode = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!vld_a && !in_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain: tvalid still high after 100 clks at %0t", $time);
    endtask

    initial begin
        int first, last, nb, nl, lpos;
        logic [7:0] got [18];

        arst = 1'b1;
        in_valid = 1'b0;
        m_tready = 1'b1;
        fill(8'h00);
        @(negedge clk);
        chk("rst_tvalid", vld_a, 1'b0);
        chk("rst_tlast", lst_a, 1'b0);
        chk("rst_tdata", dat_a, 8'h00);
        chk("rst_in_ready", rdy_a, 1'b0);
        chk("rst_pkt_count", pc_a, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready_lo", rdy_a, 1'b0);
        @(negedge clk);
        chk("rel_in_ready_hi", rdy_a, 1'b1);
        @(posedge clk);
        #1;

        // single word, byte 0 one clk after accept, nine contiguous bytes
        fill(8'h01);
        send_word();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("t1_tvalid", vld_a, 1'b1);
            chk("t1_tdata", dat_a, 8'(k + 1));
            chk("t1_tlast", lst_a, 1'b0);
        end
        @(negedge clk);
        chk("t1_idle", vld_a, 1'b0);
        @(posedge clk);
        #1;

        // two back-to-back words on the 2-word packetizer: 18 contiguous bytes
        do_reset();
        first = -1; last = -1; nb = 0; nl = 0; lpos = -1;
        fork
            begin
                fill(8'h11);
                send_word();
                fill(8'h21);
                send_word();
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (vld_b) begin
                        if (first < 0) first = c;
                        last = c;
                        if (nb < 18) got[nb] = dat_b;
                        if (lst_b) begin
                            nl++;
                            lpos = nb;
                        end
                        if (m_tready) nb++;
                    end
                end
            end
        join
        chk("t2_nbytes", nb, 18);
        chk("t2_no_bubble", last - first, 17);
        chk("t2_tlast_count", nl, 1);
        chk("t2_tlast_pos", lpos, 17);
        for (int k = 0; k < 18; k++)
            chk("t2_byte", got[k], (k < 9) ? 8'(8'h11 + k) : 8'(8'h21 + k - 9));
        chk("t2_pkt_count", pc_b, 4'd1);

        // stall on byte 04 for five clocks
        fill(8'h01);
        send_word();
        repeat (3) @(negedge clk);
        mode = 2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall_tdata", dat_a, 8'h04);
            chk("t3_stall_tvalid", vld_a, 1'b1);
            chk("t3_stall_in_ready", rdy_a, 1'b0);
        end
        mode = 0;
        for (int k = 4; k <= 9; k++) begin
            @(negedge clk);
            chk("t3_resume", dat_a, 8'(k));
        end
        @(negedge clk);
        chk("t3_idle", vld_a, 1'b0);
        @(posedge clk);
        #1;

        // 1000 random words under random backpressure and idle gaps
        do_reset();
        mode = 1;
        for (int w = 0; w < 1000; w++) begin
            fill_rand();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_word();
        end
        drain();
        chk("t4_pkt_a", pc_a, 16'd62);
        chk("t4_pkt_b", pc_b, 4'd4);
        chk("t4_pkt_c", pc_c, 8'd232);

        // reset after byte 3 of word 5, then a fresh 16-word packet
        do_reset();
        for (int w = 0; w < 5; w++) begin
            fill(8'(w * 16));
            send_word();
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        arst = 1'b1;
        @(negedge clk);
        chk("t5_rst_tvalid", vld_a, 1'b0);
        chk("t5_rst_pkt", pc_a, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        nb = 0;
        lpos = -1;
        fork
            begin
                for (int w = 0; w < 16; w++) begin
                    fill_rand();
                    send_word();
                end
            end
            begin
                for (int c = 0; c < 400 && lpos < 0; c++) begin
                    @(negedge clk);
                    if (vld_a && m_tready) begin
                        nb++;
                        if (lst_a) lpos = nb;
                    end
                end
            end
        join
        chk("t5_tlast_at", lpos, 144);
        drain();
        chk("t5_pkt_a", pc_a, 16'd1);

        // 17 packets on the 4-bit counter wrap to 1
        do_reset();
        mode = 1;
        for (int w = 0; w < 34; w++) begin
            fill_rand();
            send_word();
        end
        drain();
        chk("t6_pkt_b_wrap", pc_b, 4'd1);
        chk("t6_pkt_c", pc_c, 8'd34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
